// File: rtl/imem_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers {pc, data}
// in a small FIFO for the fetch stage, and flushes on an EX-stage redirect.
module imem_prefetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_en,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req_valid,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [31:0]              mem_rsp_data,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic          rsp_ok;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW:0]   credit;
  logic [31:0]   redirect_aligned;

  // Words already buffered plus live (non-discarded) requests must fit the FIFO.
  assign credit           = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, disc_q};
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign rsp_ok           = mem_rsp_valid && (outst_q != '0);
  assign mem_req_valid    = rst && !redirect_en && (outst_q < CW'(MAX_OUTSTANDING))
                            && (credit < (CW+1)'(DEPTH));
  assign mem_req_addr     = req_pc_q;
  assign req_fire         = mem_req_valid && mem_req_ready;
  assign push             = rsp_ok && (disc_q == '0) && !redirect_en;
  assign pop              = (count_q != '0) && inst_ready;

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign fill_count = count_q;

  always_comb begin
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q;
    disc_d   = disc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_en) begin
      // Everything still in flight becomes stale; a response this cycle is dropped.
      req_pc_d = redirect_aligned;
      rsp_pc_d = redirect_aligned;
      outst_d  = outst_q - CW'(rsp_ok);
      disc_d   = outst_q - CW'(rsp_ok);
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (req_fire) req_pc_d = req_pc_q + 32'd4;
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && (disc_q != '0)) disc_d = disc_q - 1'b1;
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      disc_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is flop-based so it can clear asynchronously with the control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      data_mem_q[wr_ptr_q] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_imem_prefetch_queue.sv
// Bench for imem_prefetch_queue: random memory/fetch behaviour checked each cycle
// against a queue-based reference of the prefetch rules.
module tb_imem_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [2:0]  fill_count;

  imem_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] data; int due; } mrsp_t;

  ent_t        mf[$];
  mrsp_t       mq[$];
  int          m_out, m_disc;
  logic [31:0] m_req_pc, m_rsp_pc;
  int          cyc;
  int          k_rdy, k_mreq, k_lmin, k_lmax, k_redir;
  bit          k_hold;
  int          hs_count;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mf.delete();
    mq.delete();
    m_out = 0;
    m_disc = 0;
    m_req_pc = 32'h0;
    m_rsp_pc = 32'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'h0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_inst_data"}, inst_data, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_fill_count"}, 32'(fill_count), 32'h0);
  endtask

  // Called at posedge+1; drives one cycle, checks at negedge, advances the model.
  task automatic one_cycle(input bit fr, input logic [31:0] frpc);
    bit exp_v;
    bit rsp;
    bit fire;
    inst_ready    = ($urandom_range(99) < k_rdy);
    mem_req_ready = ($urandom_range(99) < k_mreq);
    redirect_en   = fr || ($urandom_range(999) < k_redir);
    redirect_pc   = fr ? frpc : $urandom;
    rsp           = !k_hold && (mq.size() > 0) && (mq[0].due <= cyc);
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? mq[0].data : $urandom;
    exp_v = !redirect_en && (m_out < MAXO) && ((mf.size() + m_out - m_disc) < DEPTH);
    fire  = exp_v && mem_req_ready;
    @(negedge clk);
    chk("req_valid", 32'(mem_req_valid), 32'(exp_v));
    if (exp_v) chk("req_addr", mem_req_addr, m_req_pc);
    chk("inst_valid", 32'(inst_valid), 32'(mf.size() != 0));
    chk("fill_count", 32'(fill_count), 32'(mf.size()));
    if (mf.size() != 0) begin
      chk("inst_pc", inst_pc, mf[0].pc);
      chk("inst_data", inst_data, mf[0].data);
    end
    if (mem_req_valid && mem_req_ready) hs_count++;
    @(posedge clk);
    if (rsp) void'(mq.pop_front());
    if (redirect_en) begin
      mf.delete();
      if (rsp) m_out--;
      m_disc   = m_out;
      m_req_pc = {redirect_pc[31:2], 2'b00};
      m_rsp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (inst_ready && mf.size() != 0) void'(mf.pop_front());
      if (rsp) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else begin
          mf.push_back(ent_t'{pc: m_rsp_pc, data: mem_rsp_data});
          m_rsp_pc = m_rsp_pc + 32'd4;
        end
      end
      if (fire) begin
        mq.push_back(mrsp_t'{data: $urandom, due: cyc + int'($urandom_range(k_lmax, k_lmin))});
        m_out++;
        m_req_pc = m_req_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    k_rdy = 100; k_mreq = 100; k_lmin = 1; k_lmax = 1; k_redir = 0; k_hold = 0;
    hs_count = 0;
    cyc = 0;
    model_reset();

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // Streaming with 1-cycle memory and fetch always ready
    repeat (12) one_cycle(1'b0, 32'h0);

    // Backpressure: flush then hold fetch off
    k_rdy = 0;
    one_cycle(1'b1, 32'h1000);
    hs_count = 0;
    repeat (10) one_cycle(1'b0, 32'h0);
    chk("bp_issued", 32'(hs_count), 32'd4);
    chk("bp_full", 32'(fill_count), 32'd4);
    chk("bp_req_low", 32'(mem_req_valid), 32'h0);

    // A single pop frees exactly one credit; hold its response back
    k_hold = 1; k_rdy = 100;
    one_cycle(1'b0, 32'h0);
    k_rdy = 0; hs_count = 0;
    repeat (4) one_cycle(1'b0, 32'h0);
    chk("pop_one_req", 32'(hs_count), 32'd1);

    // Redirect coinciding with a response and a pop on a credit-full FIFO
    k_hold = 0; k_rdy = 100;
    one_cycle(1'b1, 32'h203);
    chk("redir_flush", 32'(fill_count), 32'h0);
    repeat (6) one_cycle(1'b0, 32'h0);

    // Request stall
    k_mreq = 0; k_rdy = 50;
    repeat (5) one_cycle(1'b0, 32'h0);
    k_mreq = 100; k_rdy = 100;

    // Redirect with two requests in flight
    k_lmin = 4; k_lmax = 4;
    one_cycle(1'b1, 32'h10);
    repeat (3) one_cycle(1'b0, 32'h0);
    one_cycle(1'b1, 32'h200);
    repeat (10) one_cycle(1'b0, 32'h0);

    // Address wrap
    k_lmin = 1; k_lmax = 2;
    one_cycle(1'b1, 32'hFFFF_FFF8);
    repeat (8) one_cycle(1'b0, 32'h0);

    // Randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      k_rdy   = int'($urandom_range(100, 20));
      k_mreq  = int'($urandom_range(100, 30));
      k_lmin  = 1;
      k_lmax  = int'($urandom_range(5, 1));
      k_redir = 30;
      repeat (50) one_cycle(1'b0, 32'h0);
    end

    // Asynchronous reset mid-burst
    k_redir = 0; k_rdy = 0; k_mreq = 100; k_lmax = 3;
    repeat (4) one_cycle(1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    mem_rsp_valid = 1'b0;
    redirect_en   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    k_rdy = 100; k_lmax = 1;
    repeat (8) one_cycle(1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
